// File: rtl/pipeline_pkg.sv
// Shared pipeline types: funct3 access encodings, MEM-stage FSM state, EX/MEM and MEM/WB bundles.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pipeline_pkg;

   // RV32I load/store funct3 encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } mem_state_t;

   // EX/MEM fields the memory stage needs to hold across wait states
   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] store_data;
      logic [31:0] pc_plus_4;
      logic [4:0]  rd_addr;
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_read;
      logic        mem_write;
      logic [2:0]  funct3;
   } exmem_t;

   // MEM/WB register contents, also consumed by ins_wb
   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] read_data;
      logic [31:0] pc_plus_4;
      logic [4:0]  rd_addr;
      logic        reg_write;
      logic        mem_to_reg;
      logic        valid;
   } memwb_t;

   // Byte enables for an access of size funct3[1:0] at byte offset addr_lo
   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] be;
      case (size)
         2'b00:   be = 4'b0001 << addr_lo;
         2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane steering for stores, load extension, and misaligned/illegal detection.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the results are used.
module mem_lane_align
   import pipeline_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        fault
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Pick the addressed byte and halfword out of the returned word
   always_comb begin
      byte_lane = 8'h00;
      case (addr_lo)
         2'b00: byte_lane = load_word[7:0];
         2'b01: byte_lane = load_word[15:8];
         2'b10: byte_lane = load_word[23:16];
         2'b11: byte_lane = load_word[31:24];
         default: byte_lane = 8'h00;
      endcase
      half_lane = addr_lo[1] ? load_word[31:16] : load_word[15:0];
   end

   // Extend load data, replicate store data across lanes, and flag bad accesses
   always_comb begin
      load_data = 32'h0;
      fault     = 1'b0;
      be        = lane_be(funct3[1:0], addr_lo);
      case (funct3[1:0])
         2'b00:   wdata = {4{store_data[7:0]}};
         2'b01:   wdata = {2{store_data[15:0]}};
         default: wdata = store_data;
      endcase

      case (funct3)
         F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
         F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
         F3_W:    load_data = load_word;
         F3_BU:   load_data = {24'h0, byte_lane};
         F3_HU:   load_data = {16'h0, half_lane};
         default: load_data = 32'h0;
      endcase

      if (is_load && is_store) begin
         fault = 1'b1;
      end else if (is_load) begin
         case (funct3)
            F3_B, F3_BU: fault = 1'b0;
            F3_H, F3_HU: fault = addr_lo[0];
            F3_W:        fault = |addr_lo;
            default:     fault = 1'b1;
         endcase
      end else if (is_store) begin
         case (funct3)
            F3_B:    fault = 1'b0;
            F3_H:    fault = addr_lo[0];
            F3_W:    fault = |addr_lo;
            default: fault = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/ins_mem.sv
// Memory pipeline stage: issues data loads/stores and owns the MEM/WB register.
// Latency: 1 cycle with a zero-wait access; otherwise 1 cycle after dmem_ready.
// Backpressure: stall_out holds EX/MEM while an access waits; gives up after MAX_WAIT cycles.
module ins_mem
   import pipeline_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] store_data_in,
   input  logic [31:0] pc_plus_4_in,
   input  logic [4:0]  rd_addr_in,
   input  logic        reg_write_in,
   input  logic        mem_to_reg_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic [2:0]  funct3_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        stall_out,
   output logic [31:0] alu_result_out,
   output logic [31:0] read_data_out,
   output logic [31:0] pc_plus_4_out,
   output logic [4:0]  rd_addr_out,
   output logic        reg_write_out,
   output logic        mem_to_reg_out,
   output logic        valid_out,
   output logic        misaligned_out,
   output logic        bus_err_out
);

   // Last wait cycle index; the counter starts at 1 for the cycle the request is first driven
   localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

   mem_state_t  state;
   logic [7:0]  wait_cnt;
   exmem_t      hold;
   exmem_t      cur_in;
   exmem_t      req_src;
   memwb_t      memwb_q;
   memwb_t      wb_done;
   memwb_t      wb_fault;

   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_load;
   logic        al_fault;
   logic        in_memop;
   logic        issue;
   logic        timeout;

   // Bundle the EX/MEM inputs; while waiting the request comes from the hold register instead
   always_comb begin
      cur_in            = '0;
      cur_in.alu_result = alu_result_in;
      cur_in.store_data = store_data_in;
      cur_in.pc_plus_4  = pc_plus_4_in;
      cur_in.rd_addr    = rd_addr_in;
      cur_in.reg_write  = reg_write_in;
      cur_in.mem_to_reg = mem_to_reg_in;
      cur_in.mem_read   = mem_read_in;
      cur_in.mem_write  = mem_write_in;
      cur_in.funct3     = funct3_in;
      req_src           = (state == ST_WAIT) ? hold : cur_in;
   end

   mem_lane_align u_align (
      .addr_lo    (req_src.alu_result[1:0]),
      .funct3     (req_src.funct3),
      .is_load    (req_src.mem_read),
      .is_store   (req_src.mem_write),
      .store_data (req_src.store_data),
      .load_word  (dmem_rdata),
      .be         (al_be),
      .wdata      (al_wdata),
      .load_data  (al_load),
      .fault      (al_fault)
   );

   // Request/stall decode; gated by reset so the port goes quiet the instant reset asserts
   always_comb begin
      in_memop = valid_in && (mem_read_in || mem_write_in);
      issue    = rst && (((state == ST_IDLE) && in_memop && !al_fault) || (state == ST_WAIT));
      timeout  = (state == ST_WAIT) && !dmem_ready && (wait_cnt == LAST_WAIT);
      // Stall drops in the completing or abandoning cycle so EX/MEM advances at that edge
      stall_out  = issue && !dmem_ready && !timeout;
      dmem_req   = issue;
      dmem_we    = issue && req_src.mem_write;
      dmem_addr  = issue ? {req_src.alu_result[31:2], 2'b00} : 32'h0;
      dmem_wdata = issue ? al_wdata : 32'h0;
      dmem_be    = issue ? al_be : 4'h0;
   end

   // MEM/WB candidates: a completed instruction, and the same slot with its write-back killed
   always_comb begin
      wb_done            = '0;
      wb_done.alu_result = req_src.alu_result;
      wb_done.read_data  = req_src.mem_read ? al_load : 32'h0;
      wb_done.pc_plus_4  = req_src.pc_plus_4;
      wb_done.rd_addr    = req_src.rd_addr;
      wb_done.reg_write  = req_src.reg_write;
      wb_done.mem_to_reg = req_src.mem_to_reg;
      wb_done.valid      = 1'b1;
      wb_fault           = wb_done;
      wb_fault.reg_write = 1'b0;
      wb_fault.read_data = 32'h0;
   end

   // Access FSM, hold register, wait counter and the registered MEM/WB/pulse outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_IDLE;
         wait_cnt       <= 8'd0;
         hold           <= '0;
         memwb_q        <= '0;
         misaligned_out <= 1'b0;
         bus_err_out    <= 1'b0;
      end else begin
         misaligned_out <= 1'b0;
         bus_err_out    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!valid_in) begin
                  memwb_q <= '0;
               end else if (!in_memop) begin
                  memwb_q <= wb_done;
               end else if (al_fault) begin
                  memwb_q        <= wb_fault;
                  misaligned_out <= 1'b1;
               end else if (dmem_ready) begin
                  memwb_q <= wb_done;
               end else begin
                  memwb_q  <= '0;
                  hold     <= cur_in;
                  wait_cnt <= 8'd1;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (dmem_ready) begin
                  memwb_q  <= wb_done;
                  wait_cnt <= 8'd0;
                  state    <= ST_IDLE;
               end else if (timeout) begin
                  memwb_q     <= '0;
                  bus_err_out <= 1'b1;
                  wait_cnt    <= 8'd0;
                  state       <= ST_IDLE;
               end else begin
                  memwb_q  <= '0;
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: begin
               memwb_q  <= '0;
               wait_cnt <= 8'd0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign alu_result_out = memwb_q.alu_result;
   assign read_data_out  = memwb_q.read_data;
   assign pc_plus_4_out  = memwb_q.pc_plus_4;
   assign rd_addr_out    = memwb_q.rd_addr;
   assign reg_write_out  = memwb_q.reg_write;
   assign mem_to_reg_out = memwb_q.mem_to_reg;
   assign valid_out      = memwb_q.valid;

endmodule

// File: tb/tb_ins_mem.sv
// Directed bench for ins_mem with MAX_WAIT=4.
// Latency: inputs driven 1ns after posedge, outputs sampled before the next posedge.
// Backpressure: dmem_ready driven directly by each scenario.
module tb_ins_mem;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] alu_result_in = '0;
   logic [31:0] store_data_in = '0;
   logic [31:0] pc_plus_4_in = '0;
   logic [4:0]  rd_addr_in = '0;
   logic        reg_write_in = 1'b0;
   logic        mem_to_reg_in = 1'b0;
   logic        mem_read_in = 1'b0;
   logic        mem_write_in = 1'b0;
   logic [2:0]  funct3_in = '0;
   logic        dmem_ready = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        stall_out;
   logic [31:0] alu_result_out, read_data_out, pc_plus_4_out;
   logic [4:0]  rd_addr_out;
   logic        reg_write_out, mem_to_reg_out, valid_out, misaligned_out, bus_err_out;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   ins_mem #(.MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result_in(alu_result_in),
      .store_data_in(store_data_in), .pc_plus_4_in(pc_plus_4_in), .rd_addr_in(rd_addr_in),
      .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .mem_read_in(mem_read_in),
      .mem_write_in(mem_write_in), .funct3_in(funct3_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
      .dmem_rdata(dmem_rdata), .stall_out(stall_out), .alu_result_out(alu_result_out),
      .read_data_out(read_data_out), .pc_plus_4_out(pc_plus_4_out), .rd_addr_out(rd_addr_out),
      .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out), .valid_out(valid_out),
      .misaligned_out(misaligned_out), .bus_err_out(bus_err_out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] rd, input logic rw, input logic m2r,
                        input logic mr, input logic mw, input logic [2:0] f3);
      valid_in = v; alu_result_in = alu; store_data_in = sd; pc_plus_4_in = alu + 32'd4;
      rd_addr_in = rd; reg_write_in = rw; mem_to_reg_in = m2r;
      mem_read_in = mr; mem_write_in = mw; funct3_in = f3;
   endtask

   task automatic go_idle();
      drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
      dmem_ready = 1'b0;
      dmem_rdata = 32'h0;
   endtask

   task automatic test_reset();
      tick();
      drive(1'b1, 32'h0000_0040, 32'h0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010);
      #1;
      n_checks++; if (dmem_req !== 1'b0) $display("FAIL rst_req: got %0h want 0", dmem_req); else n_pass++;
      n_checks++; if (stall_out !== 1'b0) $display("FAIL rst_stall: got %0h want 0", stall_out); else n_pass++;
      n_checks++; if (valid_out !== 1'b0) $display("FAIL rst_valid: got %0h want 0", valid_out); else n_pass++;
      n_checks++; if (alu_result_out !== 32'h0) $display("FAIL rst_alu: got %h want 0", alu_result_out); else n_pass++;
      go_idle();
      tick();
      #3 rst = 1'b1;
      tick();
   endtask

   task automatic test_passthrough();
      drive(1'b1, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
      #1;
      n_checks++; if (dmem_req !== 1'b0) $display("FAIL rtype_req: got %0h want 0", dmem_req); else n_pass++;
      tick();
      n_checks++; if (alu_result_out !== 32'h0000_1234) $display("FAIL rtype_alu: got %h want 00001234", alu_result_out); else n_pass++;
      n_checks++; if (rd_addr_out !== 5'd5) $display("FAIL rtype_rd: got %0d want 5", rd_addr_out); else n_pass++;
      n_checks++; if (valid_out !== 1'b1 || reg_write_out !== 1'b1) $display("FAIL rtype_vld_rw: got %0b%0b want 11", valid_out, reg_write_out); else n_pass++;
      n_checks++; if (read_data_out !== 32'h0) $display("FAIL rtype_rdata: got %h want 0", read_data_out); else n_pass++;
      go_idle();
   endtask

   task automatic test_lb_zero_wait();
      drive(1'b1, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
      dmem_ready = 1'b1; dmem_rdata = 32'h80FF_FF00;
      #1;
      n_checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) $display("FAIL lb_req_we: got %0b%0b want 10", dmem_req, dmem_we); else n_pass++;
      n_checks++; if (dmem_addr !== 32'h0000_0100) $display("FAIL lb_addr: got %h want 00000100", dmem_addr); else n_pass++;
      n_checks++; if (stall_out !== 1'b0) $display("FAIL lb_stall: got %0b want 0", stall_out); else n_pass++;
      tick();
      n_checks++; if (read_data_out !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", read_data_out); else n_pass++;
      n_checks++; if (valid_out !== 1'b1 || mem_to_reg_out !== 1'b1 || rd_addr_out !== 5'd7) $display("FAIL lb_ctl: got v%0b m%0b rd%0d want v1 m1 rd7", valid_out, mem_to_reg_out, rd_addr_out); else n_pass++;
      go_idle();
   endtask

   task automatic test_lhu_wait();
      int stalls = 0;
      drive(1'b1, 32'h0000_0202, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 3'b101);
      for (int c = 0; c < 3; c++) begin
         #1;
         if (stall_out === 1'b1) stalls++;
         n_checks++; if (dmem_addr !== 32'h0000_0200 || dmem_req !== 1'b1) $display("FAIL lhu_req_c%0d: got req %0b addr %h want req 1 addr 00000200", c, dmem_req, dmem_addr); else n_pass++;
         tick();
         n_checks++; if (valid_out !== 1'b0 || reg_write_out !== 1'b0) $display("FAIL lhu_bubble_c%0d: got %0b%0b want 00", c, valid_out, reg_write_out); else n_pass++;
         // upstream content changes must not disturb the held access
         alu_result_in = 32'hDEAD_0000; rd_addr_in = 5'd30; mem_write_in = 1'b1;
      end
      dmem_ready = 1'b1; dmem_rdata = 32'hBEEF_0000;
      #1;
      n_checks++; if (stall_out !== 1'b0) $display("FAIL lhu_stall_done: got %0b want 0", stall_out); else n_pass++;
      n_checks++; if (stalls !== 3) $display("FAIL lhu_stall_cycles: got %0d want 3", stalls); else n_pass++;
      tick();
      n_checks++; if (read_data_out !== 32'h0000_BEEF) $display("FAIL lhu_data: got %h want 0000beef", read_data_out); else n_pass++;
      n_checks++; if (valid_out !== 1'b1 || rd_addr_out !== 5'd9 || alu_result_out !== 32'h0000_0202) $display("FAIL lhu_ctl: got v%0b rd%0d alu %h want v1 rd9 alu 00000202", valid_out, rd_addr_out, alu_result_out); else n_pass++;
      go_idle();
   endtask

   task automatic test_store_misaligned();
      drive(1'b1, 32'h0000_0301, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
      dmem_ready = 1'b1;
      #1;
      n_checks++; if (dmem_be !== 4'b0010) $display("FAIL sb_be: got %b want 0010", dmem_be); else n_pass++;
      n_checks++; if (dmem_wdata !== 32'hABAB_ABAB) $display("FAIL sb_wdata: got %h want abababab", dmem_wdata); else n_pass++;
      n_checks++; if (dmem_we !== 1'b1 || dmem_req !== 1'b1) $display("FAIL sb_we_req: got %0b%0b want 11", dmem_we, dmem_req); else n_pass++;
      tick();
      drive(1'b1, 32'h0000_0303, 32'h0000_1234, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001);
      dmem_ready = 1'b0;
      #1;
      n_checks++; if (dmem_req !== 1'b0 || stall_out !== 1'b0) $display("FAIL sh_mis_req: got req %0b stall %0b want 0 0", dmem_req, stall_out); else n_pass++;
      tick();
      n_checks++; if (misaligned_out !== 1'b1) $display("FAIL sh_mis_pulse: got %0b want 1", misaligned_out); else n_pass++;
      n_checks++; if (valid_out !== 1'b1 || reg_write_out !== 1'b0) $display("FAIL sh_mis_wb: got v%0b rw%0b want v1 rw0", valid_out, reg_write_out); else n_pass++;
      // illegal load encoding 011
      drive(1'b1, 32'h0000_0000, 32'h0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 3'b011);
      #1;
      n_checks++; if (dmem_req !== 1'b0) $display("FAIL ld011_req: got %0b want 0", dmem_req); else n_pass++;
      tick();
      n_checks++; if (misaligned_out !== 1'b1 || reg_write_out !== 1'b0) $display("FAIL ld011_flag: got m%0b rw%0b want m1 rw0", misaligned_out, reg_write_out); else n_pass++;
      go_idle();
      tick();
      n_checks++; if (misaligned_out !== 1'b0 || valid_out !== 1'b0) $display("FAIL mis_clear: got m%0b v%0b want 0 0", misaligned_out, valid_out); else n_pass++;
   endtask

   task automatic test_back_to_back();
      dmem_ready = 1'b1;
      drive(1'b1, 32'h0000_0302, 32'h1234_CDEF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
      #1;
      n_checks++; if (dmem_be !== 4'b1100 || dmem_wdata !== 32'hCDEF_CDEF) $display("FAIL sh_lanes: got be %b wdata %h want 1100 cdefcdef", dmem_be, dmem_wdata); else n_pass++;
      tick();
      drive(1'b1, 32'h0000_0100, 32'h0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 3'b001);
      dmem_rdata = 32'h1234_8001;
      tick();
      n_checks++; if (read_data_out !== 32'hFFFF_8001) $display("FAIL lh_data: got %h want ffff8001", read_data_out); else n_pass++;
      drive(1'b1, 32'h0000_0104, 32'h0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010);
      dmem_rdata = 32'hCAFE_F00D;
      #1;
      n_checks++; if (dmem_be !== 4'b1111 || dmem_addr !== 32'h0000_0104) $display("FAIL lw_be_addr: got %b %h want 1111 00000104", dmem_be, dmem_addr); else n_pass++;
      tick();
      n_checks++; if (read_data_out !== 32'hCAFE_F00D || rd_addr_out !== 5'd11) $display("FAIL lw_data: got %h rd%0d want cafef00d rd11", read_data_out, rd_addr_out); else n_pass++;
      drive(1'b1, 32'h0000_0106, 32'h0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100);
      dmem_rdata = 32'h00A5_0000;
      tick();
      n_checks++; if (read_data_out !== 32'h0000_00A5) $display("FAIL lbu_data: got %h want 000000a5", read_data_out); else n_pass++;
      go_idle();
   endtask

   task automatic test_timeout();
      drive(1'b1, 32'h0000_0400, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010);
      for (int c = 0; c < 4; c++) begin
         #1;
         n_checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_0400) $display("FAIL to_req_c%0d: got req %0b addr %h want 1 00000400", c, dmem_req, dmem_addr); else n_pass++;
         if (c < 3) begin
            n_checks++; if (stall_out !== 1'b1) $display("FAIL to_stall_c%0d: got %0b want 1", c, stall_out); else n_pass++;
         end
         tick();
      end
      go_idle();
      #1;
      n_checks++; if (bus_err_out !== 1'b1) $display("FAIL to_buserr: got %0b want 1", bus_err_out); else n_pass++;
      n_checks++; if (dmem_req !== 1'b0 || stall_out !== 1'b0 || valid_out !== 1'b0) $display("FAIL to_release: got req %0b stall %0b v %0b want 0 0 0", dmem_req, stall_out, valid_out); else n_pass++;
      tick();
      n_checks++; if (bus_err_out !== 1'b0) $display("FAIL to_buserr_pulse: got %0b want 0", bus_err_out); else n_pass++;
   endtask

   task automatic test_reset_mid_wait();
      drive(1'b1, 32'h0000_0500, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010);
      tick();
      tick();
      #2 rst = 1'b0;
      #1;
      n_checks++; if (dmem_req !== 1'b0 || stall_out !== 1'b0) $display("FAIL mrst_req: got req %0b stall %0b want 0 0", dmem_req, stall_out); else n_pass++;
      n_checks++; if (valid_out !== 1'b0 || bus_err_out !== 1'b0 || rd_addr_out !== 5'd0) $display("FAIL mrst_outs: got v%0b be%0b rd%0d want 0 0 0", valid_out, bus_err_out, rd_addr_out); else n_pass++;
      go_idle();
      #1 rst = 1'b1;
      tick();
      drive(1'b1, 32'h0000_0508, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010);
      dmem_ready = 1'b1; dmem_rdata = 32'h1122_3344;
      #1;
      n_checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_0508) $display("FAIL mrst_fresh_req: got %0b %h want 1 00000508", dmem_req, dmem_addr); else n_pass++;
      tick();
      n_checks++; if (read_data_out !== 32'h1122_3344 || valid_out !== 1'b1 || rd_addr_out !== 5'd3) $display("FAIL mrst_fresh_wb: got %h v%0b rd%0d want 11223344 v1 rd3", read_data_out, valid_out, rd_addr_out); else n_pass++;
      go_idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_passthrough();
      test_lb_zero_wait();
      test_lhu_wait();
      test_store_misaligned();
      test_back_to_back();
      test_timeout();
      test_reset_mid_wait();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
